// File: rtl/adaptive_threshold_pkg.sv
// Shared constants for the adaptive hysteresis edge detector: default sample width,
// midscale helper and scan FSM state encoding.
package adaptive_threshold_pkg;

  localparam int ADC_WIDTH_DEF = 12;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_UPDATE = 2'd2
  } scan_st_e;

  function automatic int midscale(input int w);
    return 1 << (w - 1);
  endfunction

endpackage

// File: rtl/adaptive_threshold_minmax_scan.sv
// Min/max tracker over a 2^N_LOG2-entry window; start_i primes it, then one sample per
// cycle is absorbed. done_o is high in the cycle the last sample is presented.
`ifdef THRESHOLD_ADAPTIVE_HYST_EN
module minmax_scan
  import adaptive_threshold_pkg::*;
#(
  parameter int W      = ADC_WIDTH_DEF,
  parameter int N_LOG2 = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [W-1:0]      smp_i,
  output logic [N_LOG2-1:0] idx_o,
  output logic [W-1:0]      min_o,
  output logic [W-1:0]      max_o,
  output logic              done_o
);

  localparam logic [N_LOG2-1:0] LAST = '1;

  logic              busy_q, busy_d;
  logic [N_LOG2-1:0] cnt_q, cnt_d;
  logic [W-1:0]      min_q, min_d;
  logic [W-1:0]      max_q, max_d;

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    min_d  = min_q;
    max_d  = max_q;
    if (start_i) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      min_d  = '1;
      max_d  = '0;
    end else if (busy_q) begin
      if (smp_i < min_q) min_d = smp_i;
      if (smp_i > max_q) max_d = smp_i;
      cnt_d = cnt_q + N_LOG2'(1);
      if (cnt_q == LAST) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      min_q  <= '1;
      max_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      min_q  <= min_d;
      max_q  <= max_d;
    end
  end

  assign idx_o  = cnt_q;
  assign min_o  = min_q;
  assign max_o  = max_q;
  assign done_o = busy_q && (cnt_q == LAST);

endmodule
`endif

// File: rtl/adaptive_threshold.sv
// Hysteresis edge detector with moving-average threshold; pulse/strobes 1 cycle after a latched toggle.
// No backpressure. THRESHOLD_ADAPTIVE_HYST_EN builds the min/max scanner that adapts the hysteresis.
module adaptive_threshold
  import adaptive_threshold_pkg::*;
#(
  parameter int ADC_WIDTH  = ADC_WIDTH_DEF,
  parameter int AVG_LOG2   = 4,
  parameter int INTERVAL   = 510023,
  parameter int INTERVAL_W = 20,
  parameter int HYST_MIN   = 8,
  parameter int HYST_SHIFT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADC_WIDTH-1:0] adc_value,
  input  logic                 adc_value_change,
  output logic [ADC_WIDTH-1:0] adc_average,
  output logic [ADC_WIDTH-1:0] threshold,
  output logic [ADC_WIDTH-1:0] hysteresis,
  output logic                 avg_valid,
  output logic                 pulse,
  output logic                 edge_rise,
  output logic                 edge_fall
);

  localparam int W  = ADC_WIDTH;
  localparam int D  = 1 << AVG_LOG2;
  localparam int SW = W + AVG_LOG2;
  localparam logic [INTERVAL_W-1:0] TMR_LAST  = INTERVAL_W'(INTERVAL - 1);
  localparam logic [AVG_LOG2:0]     FILL_FULL = (AVG_LOG2 + 1)'(D);
  localparam logic [W-1:0]          MID       = W'(midscale(W));
  localparam logic [W-1:0]          HMIN      = W'(HYST_MIN);

  logic                  tog_q, tog_d;
  logic [W-1:0]          value_q, value_d;
  logic                  cmp_q, cmp_d;
  logic [INTERVAL_W-1:0] timer_q, timer_d;
  logic [AVG_LOG2-1:0]   idx_q, idx_d;
  logic [AVG_LOG2:0]     fill_q, fill_d;
  logic [SW-1:0]         sum_q, sum_d;
  logic [W-1:0]          avg_q, avg_d;
  logic                  pulse_q, pulse_d;
  logic                  rise_q, rise_d;
  logic                  fall_q, fall_d;
  logic [W-1:0]          thr_q, thr_d;
  logic [W-1:0]          hys_q, hys_d;
  logic [W-1:0]          win_q [D];

  logic          toggle;
  logic          tick;
  logic [W-1:0]  old_val;
  logic [W:0]    hi_sum;
  logic [W:0]    lo_dif;
  logic [W-1:0]  hi_bound;
  logic [W-1:0]  lo_bound;

  assign toggle = adc_value_change ^ tog_q;
  assign tick   = (timer_q == TMR_LAST);

  always_comb begin
    tog_d   = tog_q;
    value_d = value_q;
    cmp_d   = 1'b0;
    if (toggle) begin
      tog_d   = adc_value_change;
      value_d = adc_value;
      cmp_d   = 1'b1;
    end
  end

  // Entries are only subtracted once the window has wrapped; before that they are stale RAM.
  assign old_val = (fill_q == FILL_FULL) ? win_q[idx_q] : '0;

  always_comb begin
    timer_d = timer_q + INTERVAL_W'(1);
    idx_d   = idx_q;
    fill_d  = fill_q;
    sum_d   = sum_q;
    avg_d   = avg_q;
    if (tick) begin
      timer_d = '0;
      idx_d   = idx_q + AVG_LOG2'(1);
      if (fill_q != FILL_FULL) fill_d = fill_q + (AVG_LOG2 + 1)'(1);
      sum_d   = sum_q + SW'(value_q) - SW'(old_val);
      avg_d   = sum_d[SW-1:AVG_LOG2];
    end
  end

  assign hi_sum   = {1'b0, thr_q} + {1'b0, hys_q};
  assign lo_dif   = {1'b0, thr_q} - {1'b0, hys_q};
  assign hi_bound = hi_sum[W] ? '1 : hi_sum[W-1:0];
  assign lo_bound = lo_dif[W] ? '0 : lo_dif[W-1:0];

  always_comb begin
    pulse_d = pulse_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (cmp_q) begin
      if (!pulse_q && (value_q >= hi_bound)) begin
        pulse_d = 1'b1;
        rise_d  = 1'b1;
      end else if (pulse_q && (value_q <= lo_bound)) begin
        pulse_d = 1'b0;
        fall_d  = 1'b1;
      end
    end
  end

  // The stored entry is the sample latched before this cycle's toggle, if any.
  always_ff @(posedge clk) begin
    if (!rst && tick) win_q[idx_q] <= value_q;
  end

`ifdef THRESHOLD_ADAPTIVE_HYST_EN
  scan_st_e            state_q, state_d;
  logic                scan_start;
  logic                scan_done;
  logic [AVG_LOG2-1:0] scan_idx;
  logic [W-1:0]        scan_min;
  logic [W-1:0]        scan_max;
  logic [W-1:0]        span_sh;
  logic [W-1:0]        hys_new;

  minmax_scan #(
    .W      (W),
    .N_LOG2 (AVG_LOG2)
  ) u_scan (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (scan_start),
    .smp_i   (win_q[scan_idx]),
    .idx_o   (scan_idx),
    .min_o   (scan_min),
    .max_o   (scan_max),
    .done_o  (scan_done)
  );

  assign span_sh = (scan_max - scan_min) >> HYST_SHIFT;
  assign hys_new = (span_sh < HMIN) ? HMIN : span_sh;

  always_comb begin
    state_d    = state_q;
    scan_start = 1'b0;
    thr_d      = thr_q;
    hys_d      = hys_q;
    case (state_q)
      ST_IDLE: begin
        if (tick && (fill_d == FILL_FULL)) begin
          state_d    = ST_SCAN;
          scan_start = 1'b1;
        end
      end
      ST_SCAN: begin
        if (scan_done) state_d = ST_UPDATE;
      end
      ST_UPDATE: begin
        thr_d   = avg_q;
        hys_d   = hys_new;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end
`else
  logic upd_q, upd_d;

  assign upd_d = tick && (fill_d == FILL_FULL);

  always_comb begin
    thr_d = thr_q;
    hys_d = HMIN;
    if (upd_q) thr_d = avg_q;
  end

  always_ff @(posedge clk) begin
    if (rst) upd_q <= 1'b0;
    else     upd_q <= upd_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      tog_q   <= 1'b0;
      value_q <= '0;
      cmp_q   <= 1'b0;
      timer_q <= '0;
      idx_q   <= '0;
      fill_q  <= '0;
      sum_q   <= '0;
      avg_q   <= '0;
      pulse_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      thr_q   <= MID;
      hys_q   <= HMIN;
    end else begin
      tog_q   <= tog_d;
      value_q <= value_d;
      cmp_q   <= cmp_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      fill_q  <= fill_d;
      sum_q   <= sum_d;
      avg_q   <= avg_d;
      pulse_q <= pulse_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      thr_q   <= thr_d;
      hys_q   <= hys_d;
    end
  end

  assign adc_average = avg_q;
  assign threshold   = thr_q;
  assign hysteresis  = hys_q;
  assign avg_valid   = (fill_q == FILL_FULL);
  assign pulse       = pulse_q;
  assign edge_rise   = rise_q;
  assign edge_fall   = fall_q;

endmodule

// File: tb/tb_adaptive_threshold.sv
// Directed + randomized bench for adaptive_threshold against a window-level reference model.
module tb_adaptive_threshold;

  localparam int W    = 12;
  localparam int AL   = 2;
  localparam int D    = 4;
  localparam int IV   = 16;
  localparam int HMIN = 8;
  localparam int HSH  = 2;
  localparam int MAXV = 4095;
`ifdef THRESHOLD_ADAPTIVE_HYST_EN
  localparam int UPD_LAT = D + 1;
  localparam bit ADAPT   = 1'b1;
`else
  localparam int UPD_LAT = 1;
  localparam bit ADAPT   = 1'b0;
`endif

  logic         clk;
  logic         rst;
  logic [W-1:0] adc_value;
  logic         adc_value_change;
  logic [W-1:0] adc_average;
  logic [W-1:0] threshold;
  logic [W-1:0] hysteresis;
  logic         avg_valid;
  logic         pulse;
  logic         edge_rise;
  logic         edge_fall;

  adaptive_threshold #(
    .ADC_WIDTH  (W),
    .AVG_LOG2   (AL),
    .INTERVAL   (IV),
    .INTERVAL_W (8),
    .HYST_MIN   (HMIN),
    .HYST_SHIFT (HSH)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .adc_value        (adc_value),
    .adc_value_change (adc_value_change),
    .adc_average      (adc_average),
    .threshold        (threshold),
    .hysteresis       (hysteresis),
    .avg_valid        (avg_valid),
    .pulse            (pulse),
    .edge_rise        (edge_rise),
    .edge_fall        (edge_fall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  // Reference model state
  int m;
  int win[$];
  int m_avg, m_thr, m_hys, m_pulse, m_rise, m_fall;
  int lat, upd_at, nthr, nhys;
  bit pend, copy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int hi_b();
    int h = m_thr + m_hys;
    return (h > MAXV) ? MAXV : h;
  endfunction

  function automatic int lo_b();
    int l = m_thr - m_hys;
    return (l < 0) ? 0 : l;
  endfunction

  task automatic model_edge();
    if (rst) begin
      m = 0; m_pulse = 0; m_rise = 0; m_fall = 0;
      m_thr = 2048; m_hys = HMIN; m_avg = 0;
      win.delete(); pend = 1'b0; copy = 1'b0; lat = 0; upd_at = -1;
    end else begin
      m++;
      m_rise = 0; m_fall = 0;
      if (pend) begin
        if (m_pulse == 0 && lat >= hi_b()) begin
          m_pulse = 1; m_rise = 1;
        end else if (m_pulse == 1 && lat <= lo_b()) begin
          m_pulse = 0; m_fall = 1;
        end
      end
      if (m == upd_at) begin
        m_thr = nthr; m_hys = nhys;
      end
      if (m % IV == 0) begin
        int s, mn, mx;
        win.push_back(lat);
        if (win.size() > D) win.delete(0);
        s = 0; mn = MAXV; mx = 0;
        foreach (win[i]) begin
          s += win[i];
          if (win[i] < mn) mn = win[i];
          if (win[i] > mx) mx = win[i];
        end
        m_avg = s / D;
        if (win.size() == D) begin
          nthr = m_avg;
          nhys = ADAPT ? (((mx - mn) >> HSH) > HMIN ? ((mx - mn) >> HSH) : HMIN) : HMIN;
          upd_at = m + UPD_LAT;
        end
      end
      if (adc_value_change != copy) begin
        copy = adc_value_change; lat = int'(adc_value); pend = 1'b1;
      end else begin
        pend = 1'b0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("pulse", pulse, m_pulse);
    chk("edge_rise", edge_rise, m_rise);
    chk("edge_fall", edge_fall, m_fall);
    chk("avg_valid", avg_valid, (win.size() == D) ? 1 : 0);
    chk("adc_average", adc_average, m_avg);
    chk("threshold", threshold, m_thr);
    chk("hysteresis", hysteresis, m_hys);
  endtask

  task automatic toggle(input int v);
    adc_value = W'(v);
    adc_value_change = ~adc_value_change;
    step();
  endtask

  task automatic run_to(input int target);
    int guard = 0;
    while (m < target && guard < 5000) begin
      step();
      guard++;
    end
    chk("run_to_reached", m, target);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    adc_value_change = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic random_phase(input int n);
    for (int i = 0; i < n; i++) begin
      int r, v;
      r = $urandom_range(0, 3);
      if (r == 0) begin
        toggle($urandom_range(0, MAXV));
      end else if (r == 1) begin
        v = m_thr - m_hys - 1 + $urandom_range(0, 2 * m_hys + 2);
        if (v < 0) v = 0;
        if (v > MAXV) v = MAXV;
        toggle(v);
      end else if (r == 2) begin
        toggle($urandom_range(0, MAXV));
        toggle($urandom_range(0, MAXV));
      end else begin
        step();
      end
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; adc_value = '0; adc_value_change = 1'b0;
    m = 0; upd_at = -1;

    do_reset();
    chk("rst_threshold", threshold, 2048);
    chk("rst_hysteresis", hysteresis, HMIN);
    chk("rst_pulse", pulse, 0);
    chk("rst_avg_valid", avg_valid, 0);

    // Pre-fill: fixed 2048 +/- 8 band
    step();
    toggle(2056);
    step();
    chk("prefill_rise", edge_rise, 1);
    chk("prefill_pulse_hi", pulse, 1);
    step();
    chk("rise_one_cycle", edge_rise, 0);
    toggle(2041);
    step();
    chk("prefill_hold", pulse, 1);
    toggle(2040);
    step();
    chk("prefill_fall", edge_fall, 1);
    chk("prefill_pulse_lo", pulse, 0);

    // Window 1000,1000,1400,1400
    toggle(1000);
    run_to(40);
    toggle(1400);
    run_to(4 * IV);
    chk("fill_avg_valid", avg_valid, 1);
    chk("fill_average", adc_average, 1200);
    run_to(4 * IV + D + 1);
    chk("fill_threshold", threshold, 1200);
    chk("fill_hysteresis", hysteresis, ADAPT ? 100 : HMIN);

    // Constant 5: floor and low saturation
    toggle(5);
    run_to(8 * IV + D + 1);
    chk("floor_threshold", threshold, 5);
    chk("floor_hysteresis", hysteresis, HMIN);
    toggle(13);
    step();
    chk("low_set", pulse, 1);
    toggle(0);
    step();
    chk("low_sat_clear", pulse, 0);

    // Constant 4095: high saturation
    toggle(4095);
    run_to(12 * IV + D + 1);
    chk("high_threshold", threshold, 4095);
    toggle(4000);
    step();
    chk("high_clear", pulse, 0);
    toggle(4095);
    step();
    chk("high_sat_set", pulse, 1);

    random_phase(700);

    // Reset in the middle of the post-tick scan window
    begin
      int guard = 0;
      while ((m % IV) != 0 && guard < 100) begin
        step();
        guard++;
      end
    end
    step();
    step();
    do_reset();
    chk("midscan_threshold", threshold, 2048);
    chk("midscan_hysteresis", hysteresis, HMIN);
    random_phase(150);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
